// File: rtl/encoder8_3_pkg.sv
// Shared widths for the registered 8-to-3 one-hot encoder.
package encoder8_3_pkg;

  localparam int unsigned ENC_IN_W  = 8;
  localparam int unsigned ENC_OUT_W = $clog2(ENC_IN_W);

  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage : encoder8_3_pkg

// File: rtl/encoder8_3_core.sv
// Combinational priority encode: the most-significant set bit wins the index,
// plus any-set and multi-hot flags.
module encoder8_3_core
  import encoder8_3_pkg::*;
(
  input  logic [ENC_IN_W-1:0]  in,
  output logic [ENC_OUT_W-1:0] idx,
  output logic                 any,
  output logic                 multi
);

  // Ascending scan, so the highest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < ENC_IN_W; i++) begin
      if (in[i]) begin
        idx = ENC_OUT_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  always_comb begin
    any   = |in;
    multi = (in & (in - ENC_IN_W'(1))) != '0;
  end

endmodule : encoder8_3_core

// File: rtl/encoder8_3.sv
// Registered 8-to-3 one-hot encoder. Output index qualified by valid;
// err flags multi-hot input (index then reports the MSB).
module encoder8_3
  import encoder8_3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENC_IN_W-1:0]  in,
  output logic [ENC_OUT_W-1:0] out,
  output logic                 valid,
  output logic                 err
);

  logic [ENC_OUT_W-1:0] out_d, out_q;
  logic                 valid_d, valid_q;
  logic                 err_d, err_q;

  logic [ENC_OUT_W-1:0] core_idx;
  logic                 core_any;
  logic                 core_multi;

  encoder8_3_core u_core (
    .in    (in),
    .idx   (core_idx),
    .any   (core_any),
    .multi (core_multi)
  );

  // Next-state values come straight from the encode core.
  always_comb begin
    out_d   = core_idx;
    valid_d = core_any;
    err_d   = core_multi;
  end

  // Output registers with synchronous reset overriding the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule : encoder8_3

// File: tb/tb_encoder8_3.sv
// Self-checking bench for encoder8_3 using an expectation queue.
module tb_encoder8_3;

  typedef struct {
    logic [2:0] out;
    logic       valid;
    logic       err;
    bit         dc;
    logic [7:0] stim;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_v;
  logic [2:0] out;
  logic       valid;
  logic       err;

  int unsigned n_checks;
  int unsigned n_fails;
  exp_t        sb_q[$];

  encoder8_3 dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .out   (out),
    .valid (valid),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Reference: MSB-first search, popcount for multi-hot.
  function automatic exp_t model(input logic r, input logic [7:0] v);
    exp_t e;
    e.out   = 3'd0;
    e.valid = 1'b0;
    e.err   = 1'b0;
    e.dc    = 1'b0;
    e.stim  = v;
    if (!r) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin
          e.out = 3'(i);
          break;
        end
      end
      e.valid = (v != 8'h00);
      e.err   = ($countones(v) >= 2);
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic [7:0] v, input bit dc);
    exp_t e;
    @(negedge clk);
    rst  = r;
    in_v = v;
    e    = model(r, v);
    e.dc = dc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (!e.dc) begin
        check_val($sformatf("out[in=%h rst=%b]", e.stim, r), {29'd0, out}, {29'd0, e.out});
        check_val($sformatf("valid[in=%h rst=%b]", e.stim, r), {31'd0, valid}, {31'd0, e.valid});
        check_val($sformatf("err[in=%h rst=%b]", e.stim, r), {31'd0, err}, {31'd0, e.err});
        check_val("outputs_known", {31'd0, $isunknown({out, valid, err})}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] onehot_seq [7];
    logic [7:0] xvec;
    n_checks   = 0;
    n_fails    = 0;
    onehot_seq = '{8'd32, 8'd4, 8'd1, 8'd128, 8'd64, 8'd8, 8'd16};
    xvec       = 8'bx1001xzx;
    rst        = 1'b1;
    in_v       = 8'hFF;

    // Reset held two cycles with all inputs set.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);

    // One-hot sweep.
    foreach (onehot_seq[k]) step(1'b0, onehot_seq[k], 1'b0);

    // Empty input.
    step(1'b0, 8'h00, 1'b0);

    // Multi-hot.
    step(1'b0, 8'h05, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b0, 8'h81, 1'b0);

    // X/Z cycle then recovery.
    step(1'b0, xvec, 1'b1);
    step(1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h02, 1'b0);

    // Mid-stream reset pulse with steady input.
    step(1'b0, 8'h80, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b0, 8'h80, 1'b0);
    step(1'b0, 8'h80, 1'b0);

    // Random mix of one-hot and arbitrary vectors.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      if (n % 2 == 0) v = 8'(1 << $urandom_range(7, 0));
      else            v = 8'($urandom);
      step(1'b0, v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_encoder8_3
